mxu_job_scheduler: RTL and testbench
====================================

# mxu_job_scheduler

Front-end controller for the temporal MXU. Arbitrates round-robin among `NUM_REQ` requesters, each presenting a complete GEMM job (A, B, C, alpha, beta). It latches the granted job into registered MXU operand outputs, pulses the MXU `start`, and waits for `out_valid` under a timeout. It then returns the result matrix to the originating requester through a valid/ready response channel. It sits between the host-side job queues and the `temporal_mxu` instance, and it is the only block that drives `start`.

## Interface
Parameters:
- `DIM`, default 16: matrix dimension. A, B, C and the result are all DIM×DIM.
- `BIT_WIDTH`, default 4: operand width (two's complement).
- `NUM_REQ`, default 2: number of requesters. Legal range is 2..8.
- `TO_W`, default 16: width of the timeout counter.

Ports:
- `clk`, input, 1: the single clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, NUM_REQ: job offered, one bit per requester.
- `req_ready`, output, NUM_REQ: job accepted. One-hot, or all zero.
- `req_A` / `req_B` / `req_C`, input, NUM_REQ×DIM×DIM×BIT_WIDTH: per-requester operand matrices.
- `req_alpha` / `req_beta`, input, NUM_REQ×BIT_WIDTH: per-requester scalars.
- `timeout_limit`, input, TO_W: maximum number of RUN cycles. A value of 0 disables the timeout.
- `mxu_start`, output, 1: start pulse to the MXU.
- `mxu_A` / `mxu_B` / `mxu_C`, output, DIM×DIM×BIT_WIDTH: registered operands.
- `mxu_alpha` / `mxu_beta`, output, BIT_WIDTH: registered scalars.
- `mxu_out_valid`, input, 1: MXU completion.
- `mxu_out`, input, DIM×DIM×2·BIT_WIDTH: MXU result.
- `rsp_valid`, output, 1: response available.
- `rsp_ready`, input, 1: response consumed.
- `rsp_id`, output, $clog2(NUM_REQ): index of the requester that owns the response.
- `rsp_timeout`, output, 1: the job was aborted by the timeout.
- `rsp_data`, output, DIM×DIM×2·BIT_WIDTH: result matrix.
- `busy`, output, 1: high in every state except IDLE.

## Operation
FSM states and transitions:
- **IDLE:** if any `req_valid` is high, the arbiter grants. `req_ready[g]` is high for that one cycle. On the same edge, operands are copied to the `mxu_*` registers, `g` is stored in `rsp_id`, and the FSM moves to START.
- **START:** `mxu_start`=1 for exactly one cycle. The timeout counter is cleared. Next state is RUN.
- **RUN:** the timeout counter increments each cycle.
  - The first cycle with `mxu_out_valid`=1 captures `mxu_out` into `rsp_data`, sets `rsp_timeout`=0, and moves to RESP.
  - If `timeout_limit`≠0 and the counter equals `timeout_limit`, the FSM sets `rsp_data`=0 and `rsp_timeout`=1, then moves to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- **RESP:** `rsp_valid`=1. The response fields are held stable until `rsp_ready`=1, at which point the FSM moves to IDLE.

Arbitration and operand rules:
- Round-robin pointer `ptr`. The grant goes to the first requester with `req_valid` high, searching from `ptr` upward with wrap. After a grant, `ptr` ← g+1 mod NUM_REQ.
- `req_ready` is never asserted outside IDLE, so a requester's `req_valid` may remain high across jobs.
- `mxu_*` operands stay constant from the grant edge until the next grant. The MXU reads them combinationally throughout the job.
- `mxu_out_valid` is ignored in IDLE, START and RESP. A stale level from the previous job must not complete a new one.

## Timing
- Reset values: state=IDLE, `ptr`=0, and every output is 0. This includes `mxu_*`, `rsp_*`, `busy`, `req_ready` and `mxu_start`.
- Grant at edge T (`req_ready` seen high in cycle T). `mxu_start` is high in cycle T+1. RUN begins in cycle T+2.
- If `mxu_out_valid` is first sampled high in cycle R, `rsp_valid` rises in cycle R+1.
- A `rsp_ready` already high when `rsp_valid` rises completes in 1 cycle. IDLE follows, and a new grant is possible 1 cycle later.
- Minimum job-to-job spacing is therefore 4 cycles plus the MXU run time.
- A timeout fires on the cycle the counter reaches `timeout_limit`, so RUN lasts `timeout_limit`+1 cycles.
- Reset mid-operation (any state): all state returns immediately to reset values, and the in-flight job is dropped silently. `mxu_start` is not reissued.

## Structure
- Package `mxu_sched_pkg` holds:
  - `state_t` enum {IDLE, START, RUN, RESP}.
  - Typedefs `mat_t` (DIM×DIM×BIT_WIDTH) and `res_t` (DIM×DIM×2·BIT_WIDTH), parameterised through package localparams that match the top-level defaults.
- One sub-module, `rr_arbiter`, containing the combinational round-robin grant logic and the `ptr` register. Its interface is `req`, an `advance` strobe, and a one-hot `gnt` with encoded `gnt_id`.
- The FSM, operand registers, timeout counter and response register live in the top module.

## Test plan
- **Single job:** requester 0 submits A=identity, B=all 2s, C=0, alpha=1, beta=0. Expect `req_ready[0]` pulse, `mxu_start` exactly one cycle later, `rsp_valid` with `rsp_id`=0, `rsp_timeout`=0, and `rsp_data` equal to `mxu_out` at capture.
- **Round-robin:** requesters 0 and 1 hold `req_valid` continuously for 4 jobs. Grant order must be 0,1,0,1. Every `req_ready` is one-hot.
- **Backpressure:** hold `rsp_ready`=0 for 20 cycles. `rsp_valid` and `rsp_data` stay stable, `busy`=1, and there is no new grant. Release `rsp_ready`; IDLE follows in the next cycle.
- **Timeout:** `timeout_limit`=5 and the MXU model never asserts `out_valid`. Expect `rsp_timeout`=1 and `rsp_data`=0 exactly 6 RUN cycles after RUN entry. Repeat with `timeout_limit`=0: there must be no response after 1000 cycles.
- **Stale completion:** the model holds `mxu_out_valid` high through RESP and IDLE. The next job must not complete before RUN.
- **Reset mid-RUN:** assert `reset_n`=0 during RUN. All outputs go to 0 asynchronously. After release, a new request is granted normally, with `ptr` restarting at 0.

Source files
------------

// File: rtl/mxu_job_scheduler_pkg.sv
// Shared types for the MXU job scheduler.
//   state_t : scheduler FSM encoding (IDLE must stay at 0 so a reset
//             state reads as all-zero on the debug output).
//   mat_t   : one DIM x DIM operand matrix at the default geometry.
//   res_t   : one DIM x DIM result matrix (double-width elements).
package mxu_sched_pkg;

    localparam int DEF_DIM       = 16;
    localparam int DEF_BIT_WIDTH = 4;
    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_TO_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef logic [DEF_DIM*DEF_DIM*DEF_BIT_WIDTH-1:0]   mat_t;
    typedef logic [DEF_DIM*DEF_DIM*2*DEF_BIT_WIDTH-1:0] res_t;

endpackage

// File: rtl/mxu_job_scheduler_if.sv
// Bundle of every non-clock signal of the MXU job scheduler.
//   req_*          : per-requester job offer (valid/ready, A, B, C, alpha, beta)
//   timeout_limit  : max RUN cycles, 0 disables the timeout
//   mxu_*          : registered operands + start pulse towards the MXU,
//                    completion (out_valid/out) back from it
//   rsp_*          : response channel (valid/ready, id, timeout flag, data)
//   busy           : scheduler is not in IDLE
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once raised, rsp_valid and all rsp_* fields hold until that
// transfer. req_ready is asserted only by the scheduler and is one-hot or zero.
// Modport slave is the scheduler's view; master is the environment's view.
interface mxu_job_scheduler_if #(
    parameter int DIM       = 16,
    parameter int BIT_WIDTH = 4,
    parameter int NUM_REQ   = 2,
    parameter int TO_W      = 16
);
    localparam int MAT_W = DIM * DIM * BIT_WIDTH;
    localparam int RES_W = 2 * MAT_W;
    localparam int ID_W  = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][MAT_W-1:0]      req_A;
    logic [NUM_REQ-1:0][MAT_W-1:0]      req_B;
    logic [NUM_REQ-1:0][MAT_W-1:0]      req_C;
    logic [NUM_REQ-1:0][BIT_WIDTH-1:0]  req_alpha;
    logic [NUM_REQ-1:0][BIT_WIDTH-1:0]  req_beta;
    logic [TO_W-1:0]                    timeout_limit;
    logic                               mxu_start;
    logic [MAT_W-1:0]                   mxu_A;
    logic [MAT_W-1:0]                   mxu_B;
    logic [MAT_W-1:0]                   mxu_C;
    logic [BIT_WIDTH-1:0]               mxu_alpha;
    logic [BIT_WIDTH-1:0]               mxu_beta;
    logic                               mxu_out_valid;
    logic [RES_W-1:0]                   mxu_out;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [ID_W-1:0]                    rsp_id;
    logic                               rsp_timeout;
    logic [RES_W-1:0]                   rsp_data;
    logic                               busy;

    modport slave (
        input  req_valid, req_A, req_B, req_C, req_alpha, req_beta,
        input  timeout_limit, mxu_out_valid, mxu_out, rsp_ready,
        output req_ready, mxu_start, mxu_A, mxu_B, mxu_C, mxu_alpha, mxu_beta,
        output rsp_valid, rsp_id, rsp_timeout, rsp_data, busy
    );

    modport master (
        output req_valid, req_A, req_B, req_C, req_alpha, req_beta,
        output timeout_limit, mxu_out_valid, mxu_out, rsp_ready,
        input  req_ready, mxu_start, mxu_A, mxu_B, mxu_C, mxu_alpha, mxu_beta,
        input  rsp_valid, rsp_id, rsp_timeout, rsp_data, busy
    );

endinterface

// File: rtl/mxu_job_scheduler_rr_arbiter.sv
// Round-robin arbiter.
//   clk, reset_n : clock, async active-low reset (ptr returns to 0)
//   req          : request vector
//   advance      : a grant was taken this cycle; move ptr past the winner
//   gnt, gnt_id  : one-hot grant and its index (combinational)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            found;
    int              idx;

    // Scan from ptr upward with wrap; first hit wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx[ID_W-1:0]]) begin
                found                = 1'b1;
                gnt[idx[ID_W-1:0]]   = 1'b1;
                gnt_id               = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mxu_job_scheduler.sv
// MXU job scheduler: grants one requester's GEMM job round-robin, latches its
// operands into the MXU operand registers, pulses start, waits for completion
// (or timeout) and returns the result on the response channel.
//   clk, reset_n : clock, async active-low reset (drops any in-flight job)
//   bus          : request / MXU / response signals (slave modport)
//   state_o      : current FSM state, for observation
module mxu_job_scheduler
    import mxu_sched_pkg::*;
#(
    parameter int DIM       = DEF_DIM,
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int TO_W      = DEF_TO_W
) (
    input  logic                clk,
    input  logic                reset_n,
    mxu_job_scheduler_if.slave  bus,
    output state_t              state_o
);

    localparam int MAT_W = DIM * DIM * BIT_WIDTH;
    localparam int RES_W = 2 * MAT_W;
    localparam int ID_W  = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [TO_W-1:0]      cnt_q, cnt_d;
    logic [MAT_W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
    logic [BIT_WIDTH-1:0] alpha_q, alpha_d, beta_q, beta_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [RES_W-1:0]     data_q, data_d;
    logic                 to_q, to_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_id;
    logic                 grant;

    assign grant = (state_q == IDLE) && (|bus.req_valid);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .advance (grant),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        alpha_d = alpha_q;
        beta_d  = beta_q;
        id_d    = id_q;
        data_d  = data_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    a_d     = bus.req_A[gnt_id];
                    b_d     = bus.req_B[gnt_id];
                    c_d     = bus.req_C[gnt_id];
                    alpha_d = bus.req_alpha[gnt_id];
                    beta_d  = bus.req_beta[gnt_id];
                    id_d    = gnt_id;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // Completion is checked first so it wins over a same-cycle timeout.
                if (bus.mxu_out_valid) begin
                    data_d  = bus.mxu_out;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if ((bus.timeout_limit != '0) && (cnt_q == bus.timeout_limit)) begin
                    data_d  = '0;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
            id_q    <= '0;
            data_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            alpha_q <= alpha_d;
            beta_q  <= beta_d;
            id_q    <= id_d;
            data_q  <= data_d;
            to_q    <= to_d;
        end
    end

    // req_ready is combinational from req_valid; gating with reset_n keeps it
    // low while reset is held even if requesters are already offering jobs.
    assign bus.req_ready   = (reset_n && state_q == IDLE) ? gnt : '0;
    assign bus.mxu_start   = (state_q == START);
    assign bus.mxu_A       = a_q;
    assign bus.mxu_B       = b_q;
    assign bus.mxu_C       = c_q;
    assign bus.mxu_alpha   = alpha_q;
    assign bus.mxu_beta    = beta_q;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_id      = id_q;
    assign bus.rsp_timeout = to_q;
    assign bus.rsp_data    = data_q;
    assign bus.busy        = (state_q != IDLE);
    assign state_o         = state_q;

endmodule

// File: tb/tb_mxu_job_scheduler.sv
module tb_mxu_job_scheduler;
  import mxu_sched_pkg::*;

  localparam int DIM   = 16;
  localparam int BW    = 4;
  localparam int NR    = 3;
  localparam int TW    = 16;
  localparam int MAT_W = DIM * DIM * BW;
  localparam int RES_W = 2 * MAT_W;

  typedef struct {
    logic [NR-1:0] mask;
    int            exp_g;
    int            run_len;
    int            hold;
  } vec_t;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  state_t state_o;

  mxu_job_scheduler_if #(.DIM(DIM), .BIT_WIDTH(BW), .NUM_REQ(NR), .TO_W(TW)) bus ();

  mxu_job_scheduler #(.DIM(DIM), .BIT_WIDTH(BW), .NUM_REQ(NR), .TO_W(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [MAT_W-1:0] op_a [NR];
  logic [MAT_W-1:0] op_b [NR];
  logic [MAT_W-1:0] op_c [NR];
  logic [BW-1:0]    op_al[NR];
  logic [BW-1:0]    op_be[NR];

  vec_t vecs[10];

  // scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_wide(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    int k;
    total_cnt++;
    if (act === exp) pass_cnt++;
    else begin
      k = 0;
      for (int i = RES_W / 64 - 1; i >= 0; i--)
        if (act[64*i +: 64] !== exp[64*i +: 64]) k = i;
      $display("FAIL %s: word %0d got %h expected %h", name, k, act[64*k +: 64], exp[64*k +: 64]);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_res(output logic [RES_W-1:0] r);
    for (int i = 0; i < RES_W / 32; i++) r[32*i +: 32] = $urandom;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NR; i++) begin
      bus.req_A[i]     = op_a[i];
      bus.req_B[i]     = op_b[i];
      bus.req_C[i]     = op_c[i];
      bus.req_alpha[i] = op_al[i];
      bus.req_beta[i]  = op_be[i];
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NR; i++) begin
      for (int w = 0; w < MAT_W / 32; w++) begin
        op_a[i][32*w +: 32] = $urandom;
        op_b[i][32*w +: 32] = $urandom;
        op_c[i][32*w +: 32] = $urandom;
      end
      op_al[i] = BW'($urandom_range(0, (1 << BW) - 1));
      op_be[i] = BW'($urandom_range(0, (1 << BW) - 1));
    end
    drive_ops();
  endtask

  // One complete job, starting in an IDLE cycle. The MXU model asserts
  // out_valid after run_len RUN cycles with data res; hold is the number of
  // extra RESP cycles with rsp_ready low.
  task automatic run_job(input logic [NR-1:0] mask, input int exp_g, input int run_len,
                         input int hold, input logic [RES_W-1:0] res, input bit keep_valid);
    logic [MAT_W-1:0] ea, eb, ec;
    logic [BW-1:0]    eal, ebe;
    logic [RES_W-1:0] junk;
    int waited;
    int bad;
    bit got;
    bus.req_valid = mask;
    bus.rsp_ready = (hold == 0);
    got = 1'b0;
    waited = 0;
    #1;
    while (!got && waited < 20) begin
      if (bus.req_ready != '0) got = 1'b1;
      else begin
        tick();
        #1;
        waited++;
      end
    end
    check("grant_seen", 64'(got), 64'd1);
    if (!got) begin
      bus.req_valid = '0;
      return;
    end
    check("req_ready_grant", 64'(bus.req_ready), 64'd1 << exp_g);
    ea = op_a[exp_g];
    eb = op_b[exp_g];
    ec = op_c[exp_g];
    eal = op_al[exp_g];
    ebe = op_be[exp_g];
    tick();
    #1;
    check("mxu_start_pulse", 64'(bus.mxu_start), 64'd1);
    check("busy_in_start", 64'(bus.busy), 64'd1);
    check("no_ready_in_start", 64'(bus.req_ready), 64'd0);
    check_wide("mxu_A", RES_W'(bus.mxu_A), RES_W'(ea));
    check_wide("mxu_B", RES_W'(bus.mxu_B), RES_W'(eb));
    check_wide("mxu_C", RES_W'(bus.mxu_C), RES_W'(ec));
    check("mxu_alpha", 64'(bus.mxu_alpha), 64'(eal));
    check("mxu_beta", 64'(bus.mxu_beta), 64'(ebe));
    randomize_ops();
    tick();
    #1;
    check("start_one_cycle", 64'(bus.mxu_start), 64'd0);
    check("state_run", 64'(state_o), 64'(RUN));
    bad = 0;
    for (int i = 1; i < run_len; i++) begin
      tick();
      #1;
      if (bus.rsp_valid || bus.req_ready != '0 || bus.mxu_start) bad++;
    end
    check("run_quiet", 64'(bad), 64'd0);
    bus.mxu_out = res;
    bus.mxu_out_valid = 1'b1;
    tick();
    bus.mxu_out_valid = keep_valid;
    rand_res(junk);
    bus.mxu_out = junk;
    #1;
    check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("rsp_id", 64'(bus.rsp_id), 64'(exp_g));
    check("rsp_timeout_clear", 64'(bus.rsp_timeout), 64'd0);
    check_wide("rsp_data", bus.rsp_data, res);
    check_wide("mxu_A_held", RES_W'(bus.mxu_A), RES_W'(ea));
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      #1;
      if (!bus.rsp_valid || bus.rsp_data !== res || !bus.busy || bus.req_ready != '0 || state_o != RESP) bad++;
    end
    if (hold > 0) check("backpressure_hold", 64'(bad), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    #1;
    check("idle_after_rsp", 64'(bus.busy), 64'd0);
    check("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
    bus.req_valid = '0;
  endtask

  logic [RES_W-1:0] res;
  int bad;

  initial begin
    // vector table: grant order from ptr=0
    vecs[0] = '{3'b011, 0, 1, 0};
    vecs[1] = '{3'b011, 1, 3, 0};
    vecs[2] = '{3'b011, 0, 1, 0};
    vecs[3] = '{3'b011, 1, 2, 0};
    vecs[4] = '{3'b100, 2, 5, 0};
    vecs[5] = '{3'b110, 1, 1, 0};
    vecs[6] = '{3'b111, 2, 2, 20};
    vecs[7] = '{3'b101, 0, 1, 0};
    vecs[8] = '{3'b101, 2, 4, 0};
    vecs[9] = '{3'b001, 0, 1, 0};

    bus.req_valid = 3'b111;
    bus.rsp_ready = 1'b1;
    bus.mxu_out_valid = 1'b0;
    bus.mxu_out = '0;
    bus.timeout_limit = TW'(100);
    randomize_ops();

    // reset state
    tick();
    tick();
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_mxu_start", 64'(bus.mxu_start), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("rst_mxu_alpha", 64'(bus.mxu_alpha), 64'd0);
    check_wide("rst_mxu_A", RES_W'(bus.mxu_A), '0);
    check_wide("rst_rsp_data", bus.rsp_data, '0);
    check("rst_state", 64'(state_o), 64'(IDLE));
    reset_n = 1'b1;
    bus.req_valid = '0;

    // table-driven round-robin / latency / backpressure
    for (int v = 0; v < 10; v++) begin
      rand_res(res);
      run_job(vecs[v].mask, vecs[v].exp_g, vecs[v].run_len, vecs[v].hold, res, 1'b0);
    end

    // single job: identity x all-2s, alpha=1, beta=0 -> all-2s result
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        op_a[0][(r*DIM+c)*BW +: BW] = (r == c) ? BW'(1) : BW'(0);
        op_b[0][(r*DIM+c)*BW +: BW] = BW'(2);
      end
    op_c[0] = '0;
    op_al[0] = BW'(1);
    op_be[0] = BW'(0);
    drive_ops();
    for (int e = 0; e < DIM * DIM; e++) res[e*2*BW +: 2*BW] = 8'd2;
    run_job(3'b001, 0, 3, 0, res, 1'b0);

    // stale completion: out_valid held high through RESP and IDLE
    rand_res(res);
    run_job(3'b010, 1, 2, 0, res, 1'b1);
    check("stale_level_present", 64'(bus.mxu_out_valid), 64'd1);
    rand_res(res);
    run_job(3'b011, 0, 1, 0, res, 1'b0);

    // timeout with limit 5: RUN lasts 6 cycles
    bus.timeout_limit = TW'(5);
    bus.req_valid = 3'b001;
    #1;
    check("to_grant", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = '0;
    #1;
    check("to_start", 64'(bus.mxu_start), 64'd1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      if (bus.rsp_valid) bad++;
    end
    check("to_not_early", 64'(bad), 64'd0);
    tick();
    #1;
    check("to_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("to_rsp_timeout", 64'(bus.rsp_timeout), 64'd1);
    check("to_rsp_id", 64'(bus.rsp_id), 64'd0);
    check_wide("to_rsp_data", bus.rsp_data, '0);
    tick();
    #1;
    check("to_idle", 64'(bus.busy), 64'd0);

    // timeout disabled: no response after 1000 cycles, then reset mid-RUN
    bus.timeout_limit = '0;
    bus.req_valid = 3'b001;
    #1;
    check("nto_grant", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = '0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      #1;
      if (bus.rsp_valid) bad++;
    end
    check("nto_no_rsp", 64'(bad), 64'd0);
    check("nto_busy", 64'(bus.busy), 64'd1);
    check("nto_state_run", 64'(state_o), 64'(RUN));
    bus.req_valid = 3'b011;
    reset_n = 1'b0;
    #1;
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_req_ready", 64'(bus.req_ready), 64'd0);
    check("mrst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    check("mrst_state", 64'(state_o), 64'(IDLE));
    check_wide("mrst_mxu_A", RES_W'(bus.mxu_A), '0);
    check_wide("mrst_mxu_B", RES_W'(bus.mxu_B), '0);
    tick();
    tick();
    reset_n = 1'b1;
    bus.req_valid = '0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      if (bus.mxu_start || bus.busy) bad++;
    end
    check("no_restart_after_rst", 64'(bad), 64'd0);
    rand_res(res);
    run_job(3'b011, 0, 2, 0, res, 1'b0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
